sync_fifo_flags: RTL

Parametrised single-clock FIFO, next generation of the team's basic synchronous FIFO. Adds:
- concurrent read and write in the same cycle
- occupancy count and programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush
- selectable standard or first-word-fall-through (FWFT) read mode

Used as the general buffering element between streaming stages in one clock domain.

---
 rtl/sync_fifo_flags.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds,
// sticky overflow/underflow errors, synchronous flush and optional FWFT read mode.
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];

  logic [PW-1:0]    wr_ptr_r, rd_ptr_r, count_r;
  logic             full_r, empty_r, af_r, ae_r;
  logic             ovf_r, unf_r, rd_valid_r;
  logic [WIDTH-1:0] rd_data_r;

  logic             wr_acc_s, rd_acc_s;
  logic [PW-1:0]    wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic             full_nxt_s, empty_nxt_s, af_nxt_s, ae_nxt_s;
  logic             ovf_nxt_s, unf_nxt_s, rd_valid_nxt_s;
  logic [WIDTH-1:0] rd_data_nxt_s;
  logic [AW-1:0]    head_addr_s;

  // Next pointers, error flags and status flags from pre-edge registered state
  always_comb begin
    wr_acc_s     = wr_en & ~full_r;
    rd_acc_s     = rd_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    ovf_nxt_s    = ovf_r;
    unf_nxt_s    = unf_r;
    if (flush) begin
      wr_ptr_nxt_s = {PW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
      ovf_nxt_s    = 1'b0;
      unf_nxt_s    = 1'b0;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_acc_s};
      rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, rd_acc_s};
      ovf_nxt_s    = ovf_r | (wr_en & full_r);
      unf_nxt_s    = unf_r | (rd_en & empty_r);
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    full_nxt_s  = (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]) &&
                  (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]);
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    af_nxt_s    = (count_nxt_s >= PW'(AF_THRESH));
    ae_nxt_s    = (count_nxt_s <= PW'(AE_THRESH));
  end

  // Read-side output data and valid for the selected read mode
  always_comb begin
    head_addr_s    = rd_ptr_nxt_s[AW-1:0];
    rd_data_nxt_s  = rd_data_r;
    rd_valid_nxt_s = 1'b0;
    if (flush) begin
      rd_data_nxt_s  = rd_data_r;
      rd_valid_nxt_s = 1'b0;
    end else if (FWFT != 0) begin
      rd_valid_nxt_s = ~empty_nxt_s;
      // The new head may be the word being written this very edge
      if (wr_acc_s && (wr_ptr_r[AW-1:0] == head_addr_s)) begin
        rd_data_nxt_s = wr_data;
      end else begin
        rd_data_nxt_s = mem_r[head_addr_s];
      end
    end else if (rd_acc_s) begin
      rd_data_nxt_s  = mem_r[rd_ptr_r[AW-1:0]];
      rd_valid_nxt_s = 1'b1;
    end else begin
      rd_data_nxt_s  = rd_data_r;
      rd_valid_nxt_s = 1'b0;
    end
  end

  // State and registered output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      count_r    <= {PW{1'b0}};
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      af_r       <= (AF_THRESH == 0) ? 1'b1 : 1'b0;
      ae_r       <= 1'b1;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {WIDTH{1'b0}};
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= full_nxt_s;
      empty_r    <= empty_nxt_s;
      af_r       <= af_nxt_s;
      ae_r       <= ae_nxt_s;
      ovf_r      <= ovf_nxt_s;
      unf_r      <= unf_nxt_s;
      rd_valid_r <= rd_valid_nxt_s;
      rd_data_r  <= rd_data_nxt_s;
    end
  end

  // Storage array; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_acc_s && !flush) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data      = rd_data_r;
  assign rd_valid     = rd_valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign count        = count_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule
